// File: rtl/pmem_arbiter.sv
// Arbiter between the L1 demand path and the stream-buffer prefetch path in front of
// the single line-wide physical-memory port; demand has priority, bounded by a starvation counter.
module pmem_arbiter #(
  parameter int MAX_STARVE = 4,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dem_read,
  input  logic                  dem_write,
  input  logic [31:0]           dem_addr,
  input  logic [LINE_WIDTH-1:0] dem_wdata,
  output logic [LINE_WIDTH-1:0] dem_rdata,
  output logic                  dem_resp,
  input  logic                  pf_read,
  input  logic [31:0]           pf_addr,
  output logic [LINE_WIDTH-1:0] pf_rdata,
  output logic                  pf_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [31:0]           mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  localparam int CW = $clog2(MAX_STARVE + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_STARVE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEM  = 2'd1,
    PF   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  pf_pending_q, pf_pending_d;
  logic [26:0]           pf_line_q, pf_line_d;
  logic [26:0]           pf_gnt_line_q, pf_gnt_line_d;
  logic [26:0]           dem_line_q, dem_line_d;
  logic                  dem_we_q, dem_we_d;
  logic [LINE_WIDTH-1:0] dem_wdata_q, dem_wdata_d;
  logic [CW-1:0]         starve_cnt_q, starve_cnt_d;

  logic dem_req;
  logic starved;
  logic unused_addr_bits;

  assign dem_req          = dem_read | dem_write;
  assign starved          = pf_pending_q && (starve_cnt_q == MAX_C);
  assign unused_addr_bits = ^{dem_addr[4:0], pf_addr[4:0]};

  always_comb begin
    state_d       = state_q;
    pf_pending_d  = pf_pending_q;
    pf_line_d     = pf_line_q;
    pf_gnt_line_d = pf_gnt_line_q;
    dem_line_d    = dem_line_q;
    dem_we_d      = dem_we_q;
    dem_wdata_d   = dem_wdata_q;
    starve_cnt_d  = starve_cnt_q;
    dem_rdata     = '0;
    dem_resp      = 1'b0;
    pf_rdata      = '0;
    pf_resp       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_addr      = 32'd0;
    mem_wdata     = '0;

    // Newest prefetch pulse wins while the request is still waiting for a grant.
    if (pf_read) begin
      pf_pending_d = 1'b1;
      pf_line_d    = pf_addr[31:5];
    end

    case (state_q)
      IDLE: begin
        if (dem_req && !starved) begin
          state_d     = DEM;
          dem_line_d  = dem_addr[31:5];
          dem_we_d    = dem_write;
          dem_wdata_d = dem_wdata;
          if (pf_pending_q && (starve_cnt_q != MAX_C)) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
          end
        end else if (pf_pending_q || pf_read) begin
          state_d      = PF;
          starve_cnt_d = '0;
          // An already-latched request is granted first; a same-cycle pulse then stays pending.
          if (pf_pending_q) begin
            pf_gnt_line_d = pf_line_q;
            pf_pending_d  = pf_read;
          end else begin
            pf_gnt_line_d = pf_addr[31:5];
            pf_pending_d  = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DEM: begin
        mem_read  = ~dem_we_q;
        mem_write = dem_we_q;
        mem_addr  = {dem_line_q, 5'b0};
        mem_wdata = dem_we_q ? dem_wdata_q : '0;
        if (mem_resp) begin
          dem_resp  = 1'b1;
          dem_rdata = mem_rdata;
          state_d   = IDLE;
        end
      end
      PF: begin
        mem_read = 1'b1;
        mem_addr = {pf_gnt_line_q, 5'b0};
        if (mem_resp) begin
          pf_resp  = 1'b1;
          pf_rdata = mem_rdata;
          state_d  = IDLE;
          // A demand read of the same line rides on this response.
          if (dem_read && !dem_write && (dem_addr[31:5] == pf_gnt_line_q)) begin
            dem_resp  = 1'b1;
            dem_rdata = mem_rdata;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pf_pending_q  <= 1'b0;
      pf_line_q     <= 27'd0;
      pf_gnt_line_q <= 27'd0;
      dem_line_q    <= 27'd0;
      dem_we_q      <= 1'b0;
      dem_wdata_q   <= '0;
      starve_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      pf_pending_q  <= pf_pending_d;
      pf_line_q     <= pf_line_d;
      pf_gnt_line_q <= pf_gnt_line_d;
      dem_line_q    <= dem_line_d;
      dem_we_q      <= dem_we_d;
      dem_wdata_q   <= dem_wdata_d;
      starve_cnt_q  <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: a latency-programmable memory model, expected
// issues/responses queued at stimulus time and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_pmem_arbiter;

  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          dem_read, dem_write, pf_read;
  logic [31:0]   dem_addr, pf_addr;
  logic [LW-1:0] dem_wdata;
  logic [LW-1:0] dem_rdata, pf_rdata;
  logic          dem_resp, pf_resp;
  logic          mem_read, mem_write, mem_resp;
  logic [31:0]   mem_addr;
  logic [LW-1:0] mem_wdata, mem_rdata;

  typedef struct {
    logic          we;
    logic [31:0]   addr;
    logic [LW-1:0] wdata;
  } iss_t;

  iss_t          exp_iss[$];
  logic [LW-1:0] exp_dem[$];
  logic [LW-1:0] exp_pf[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_resp_cyc = 0;
  int last_gap = 0;
  int dem_resp_cyc = -1;
  int pf_resp_cyc = -1;
  int mem_lat = 3;
  int inj_req = 0;
  int inj_ack = 0;
  int wcnt = 0;
  logic resp_on = 1'b0;

  always #5 clk = ~clk;

  pmem_arbiter #(.MAX_STARVE(4), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .dem_read(dem_read), .dem_write(dem_write), .dem_addr(dem_addr),
    .dem_wdata(dem_wdata), .dem_rdata(dem_rdata), .dem_resp(dem_resp),
    .pf_read(pf_read), .pf_addr(pf_addr), .pf_rdata(pf_rdata), .pf_resp(pf_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  function automatic logic [LW-1:0] line_data(input logic [31:0] a);
    logic [LW-1:0] d;
    for (int i = 0; i < 8; i++) begin
      d[i*32 +: 32] = {a[31:5], 5'b0} ^ (32'(i) * 32'h1111_1111) ^ 32'hC0DE_0000;
    end
    return d;
  endfunction

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: responds mem_lat cycles into a request; can also inject a stray response.
  initial begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (resp_on) begin
        mem_resp = 1'b0; mem_rdata = '0; resp_on = 1'b0; wcnt = 0;
      end else if (inj_req != inj_ack) begin
        inj_ack   = inj_req;
        mem_resp  = 1'b1; mem_rdata = {8{32'hDEAD_BEEF}}; resp_on = 1'b1;
      end else if (mem_read || mem_write) begin
        wcnt++;
        if (wcnt >= mem_lat) begin
          mem_resp  = 1'b1;
          mem_rdata = mem_read ? line_data(mem_addr) : '0;
          resp_on   = 1'b1;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: compares each new issue and each response against the scoreboard queues.
  initial begin
    logic        preq;
    logic [31:0] paddr;
    iss_t        e;
    preq = 1'b0; paddr = 32'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        preq = 1'b0;
      end else begin
        if (dem_resp) begin
          dem_resp_cyc = cyc; last_resp_cyc = cyc;
          if (exp_dem.size() == 0) chk("dem_resp_unexpected", 256'd1, 256'd0);
          else chk("dem_rdata", dem_rdata, exp_dem.pop_front());
        end else begin
          chk("dem_rdata_zero", dem_rdata, '0);
        end
        if (pf_resp) begin
          pf_resp_cyc = cyc; last_resp_cyc = cyc;
          if (exp_pf.size() == 0) chk("pf_resp_unexpected", 256'd1, 256'd0);
          else chk("pf_rdata", pf_rdata, exp_pf.pop_front());
        end else begin
          chk("pf_rdata_zero", pf_rdata, '0);
        end
        if ((mem_read || mem_write) && !preq) begin
          last_gap = cyc - last_resp_cyc;
          if (exp_iss.size() == 0) begin
            chk("issue_unexpected", 256'(mem_addr), 256'hFFFF_FFFF);
          end else begin
            e = exp_iss.pop_front();
            chk("issue_addr", 256'(mem_addr), 256'({e.addr[31:5], 5'b0}));
            chk("issue_write", 256'(mem_write), 256'(e.we));
            chk("issue_read", 256'(mem_read), 256'(!e.we));
            if (e.we) chk("issue_wdata", mem_wdata, e.wdata);
          end
        end else if ((mem_read || mem_write) && preq) begin
          chk("hold_addr", 256'(mem_addr), 256'(paddr));
        end
        preq  = mem_read || mem_write;
        paddr = mem_addr;
      end
    end
  end

  task automatic dem_op(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [LW-1:0] wd);
    int n;
    exp_dem.push_back(wr ? '0 : line_data(a));
    dem_read = rd; dem_write = wr; dem_addr = a; dem_wdata = wd;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!dem_resp && n < 400);
    if (!dem_resp) chk("dem_timeout", 256'd0, 256'd1);
    @(posedge clk); #1;
    dem_read = 1'b0; dem_write = 1'b0;
  endtask

  task automatic pf_pulse(input logic [31:0] a);
    pf_read = 1'b1; pf_addr = a;
    @(posedge clk); #1;
    pf_read = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_iss.size() != 0 || exp_dem.size() != 0 || exp_pf.size() != 0 ||
            mem_read || mem_write) && n < 300) begin
      @(negedge clk); n++;
    end
    if (n >= 300) chk("drain_timeout", 256'd0, 256'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [LW-1:0] wd;
    rst = 1'b0; dem_read = 1'b0; dem_write = 1'b0; dem_addr = 32'd0; dem_wdata = '0;
    pf_read = 1'b0; pf_addr = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_mem_read", 256'(mem_read), 256'd0);
    chk("reset_mem_write", 256'(mem_write), 256'd0);
    chk("reset_mem_addr", 256'(mem_addr), 256'd0);
    chk("reset_starve", 256'(dut.starve_cnt_q), 256'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Reset in the middle of a demand read, then a stray mem_resp.
    mem_lat = 50;
    exp_iss.push_back('{1'b0, 32'h0000_1040, '0});
    dem_read = 1'b1; dem_addr = 32'h0000_1040;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_mem_read", 256'(mem_read), 256'd1);
    rst = 1'b0;
    #1;
    chk("rst_mem_read", 256'(mem_read), 256'd0);
    chk("rst_mem_addr", 256'(mem_addr), 256'd0);
    chk("rst_dem_resp", 256'(dem_resp), 256'd0);
    dem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    inj_req++;
    @(negedge clk);
    chk("stray_resp_seen", 256'(mem_resp), 256'd1);
    chk("stray_dem_resp", 256'(dem_resp), 256'd0);
    chk("stray_pf_resp", 256'(pf_resp), 256'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_idle", 256'(mem_read | mem_write), 256'd0);

    // Prefetch pulse latched during a demand, issued right after the IDLE cycle.
    mem_lat = 5;
    exp_iss.push_back('{1'b0, 32'h0000_5000, '0});
    exp_iss.push_back('{1'b0, 32'h0000_2000, '0});
    exp_pf.push_back(line_data(32'h0000_2000));
    fork
      dem_op(1'b1, 1'b0, 32'h0000_5000, '0);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        pf_pulse(32'h0000_2000);
      end
    join
    drain();
    chk("b2b_gap", 256'(last_gap), 256'd2);

    // Two prefetch pulses during one demand: the newer address wins.
    mem_lat = 6;
    exp_iss.push_back('{1'b0, 32'h0000_6000, '0});
    exp_iss.push_back('{1'b0, 32'h0000_0120, '0});
    exp_pf.push_back(line_data(32'h0000_0120));
    fork
      dem_op(1'b1, 1'b0, 32'h0000_6000, '0);
      begin
        @(posedge clk); #1;
        pf_pulse(32'h0000_0100);
        @(posedge clk); #1;
        pf_pulse(32'h0000_0120);
      end
    join
    drain();

    // Starvation bound: four demand grants with a prefetch pending, then the prefetch.
    mem_lat = 3;
    exp_iss.push_back('{1'b0, 32'h0000_8000, '0});
    for (int i = 1; i <= 4; i++) exp_iss.push_back('{1'b0, 32'h0000_9000 + 32'(i) * 32'h20, '0});
    exp_iss.push_back('{1'b0, 32'h0000_7000, '0});
    exp_iss.push_back('{1'b0, 32'h0000_90A0, '0});
    exp_pf.push_back(line_data(32'h0000_7000));
    fork
      dem_op(1'b1, 1'b0, 32'h0000_8000, '0);
      begin
        @(posedge clk); #1;
        pf_pulse(32'h0000_7000);
      end
    join
    chk("starve_first", 256'(dut.starve_cnt_q), 256'd0);
    for (int i = 1; i <= 5; i++) begin
      dem_op(1'b1, 1'b0, 32'h0000_9000 + 32'(i) * 32'h20, '0);
      if (i == 4) chk("starve_at_max", 256'(dut.starve_cnt_q), 256'd4);
    end
    drain();
    chk("starve_cleared", 256'(dut.starve_cnt_q), 256'd0);

    // Demand read of the in-flight prefetch line is merged into its response.
    mem_lat = 5;
    exp_iss.push_back('{1'b0, 32'h0000_3020, '0});
    exp_pf.push_back(line_data(32'h0000_3020));
    pf_pulse(32'h0000_3020);
    @(posedge clk); #1;
    @(posedge clk); #1;
    dem_op(1'b1, 1'b0, 32'h0000_303C, '0);
    drain();
    chk("merge_same_cycle", 256'(dem_resp_cyc), 256'(pf_resp_cyc));

    // Write wins over a simultaneous read.
    mem_lat = 2;
    wd = {8{32'hA5A5_5A5A}} ^ line_data(32'h0000_0040);
    exp_iss.push_back('{1'b1, 32'h0000_0040, wd});
    dem_op(1'b1, 1'b1, 32'h0000_0040, wd);
    drain();

    chk("iss_queue_empty", 256'(exp_iss.size()), 256'd0);
    chk("dem_queue_empty", 256'(exp_dem.size()), 256'd0);
    chk("pf_queue_empty", 256'(exp_pf.size()), 256'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Two-client arbiter between the L1 cache's demand path and the stream buffer's prefetch path, in front of the single 256-bit physical-memory (cacheline adaptor) port. Demand reads and writes have priority. Single-cycle prefetch pulses are latched so none is lost while memory is busy. A starvation counter bounds how long a pending prefetch can wait. A demand read that targets the line currently being prefetched is served by that prefetch's response, without a second memory transaction.

## Interface
- MAX_STARVE, 4, consecutive demand grants allowed while a prefetch is pending; the next grant goes to the prefetch
- LINE_WIDTH, 256, line data width
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- dem_read  in  1  L1 demand read; held until dem_resp
- dem_write  in  1  L1 writeback; held until dem_resp; wins if asserted together with dem_read
- dem_addr  in  32  demand byte address; low 5 bits ignored
- dem_wdata  in  LINE_WIDTH  writeback line
- dem_rdata  out  LINE_WIDTH  demand read line
- dem_resp  out  1  demand completion, 1-cycle pulse
- pf_read  in  1  stream-buffer prefetch request; may be a 1-cycle pulse
- pf_addr  in  32  prefetch byte address; low 5 bits ignored
- pf_rdata  out  LINE_WIDTH  prefetch line (stream buffer data_in)
- pf_resp  out  1  prefetch completion (stream buffer pmem_resp), 1-cycle pulse
- mem_read, mem_write  out  1  physical-memory request, held until mem_resp
- mem_addr  out  32  line-aligned address, {addr[31:5],5'b0}
- mem_wdata  out  LINE_WIDTH  write line
- mem_rdata  in  LINE_WIDTH  read line
- mem_resp  in  1  memory completion, 1-cycle pulse

## Operation
- States: IDLE, DEM, PF; reset state IDLE.
- Prefetch latch: pf_pending, pf_line[26:0].
  - pf_read high in any cycle sets pf_pending and captures pf_addr[31:5].
  - A newer pulse while pending and not yet granted overwrites the address (newest wins).
  - pf_pending clears on the IDLE->PF transition.
  - A pulse in the same cycle as that transition is captured as a new pending request.
- Demand latch: on IDLE->DEM, capture dem_line, the op (write if dem_write), and dem_wdata.
- IDLE arbitration, evaluated each cycle:
  - If a demand is present and not (pf_pending and starve_cnt == MAX_STARVE) -> DEM.
  - Else if pf_pending (including a pulse arriving this cycle) -> PF.
  - Else stay in IDLE.
- starve_cnt, width $clog2(MAX_STARVE+1):
  - increments on each IDLE->DEM while pf_pending is 1;
  - clears on IDLE->PF;
  - holds otherwise;
  - saturates at MAX_STARVE.
- DEM:
  - mem_read or mem_write = latched op; mem_addr = {dem_line,5'b0}; mem_wdata = latched data.
  - On mem_resp: dem_resp = 1 and dem_rdata = mem_rdata (combinational), then -> IDLE.
- PF:
  - mem_read = 1, mem_addr = {pf_line_granted,5'b0}.
  - On mem_resp: pf_resp = 1 and pf_rdata = mem_rdata, then -> IDLE.
  - Merge: if in the same cycle dem_read = 1, dem_write = 0, and dem_addr[31:5] == granted line, then dem_resp = 1 and dem_rdata = mem_rdata too. The demand is then complete and is not re-issued.
- Demand writes never merge.
- Outputs not being driven are 0; dem_rdata and pf_rdata are 0 unless their resp is high.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE; pf_pending = 0; starve_cnt = 0; latched lines and data = 0.
  - All outputs 0.
- A mem_resp arriving while in IDLE, including after a mid-transaction reset, is ignored; no resp is generated.
- Grant latency: a request seen in cycle N drives mem_read/mem_write from cycle N+1. These outputs are a function of registered state only.
- Response latency: 0 cycles. The client resp is in the same cycle as mem_resp.
- Back-to-back: the earliest next grant is the cycle after resp (IDLE for one cycle). Minimum issue-to-issue spacing is 2 cycles beyond memory latency.
- The requester must drop dem_read/dem_write in the cycle after dem_resp. The one IDLE cycle guarantees no duplicate issue.
- mem_addr, mem_wdata, mem_read and mem_write are stable for the whole DEM/PF residency.

## Test plan
- Reset mid-DEM read of 0x0000_1040, mem_resp pulsed 2 cycles later -> all outputs 0 immediately; no dem_resp; state IDLE.
- pf_read pulse (1 cycle) addr 0x0000_2000 during a DEM transaction whose mem_resp comes 5 cycles later -> cycle after dem_resp, mem_read = 1 with mem_addr 0x0000_2000; pf_resp with mem_rdata.
- Two pf_read pulses 0x100, then 0x120, both while in DEM -> only 0x120 is issued; exactly one pf_resp.
- Continuous demand reads with a prefetch pending, MAX_STARVE = 4 -> 4 DEM grants, then a PF grant, then starve_cnt = 0.
- PF in flight for 0x0000_3020 and dem_read for 0x0000_303C asserted 2 cycles before mem_resp -> dem_resp and pf_resp in the same cycle with identical data; no second memory read.
- dem_write and dem_read both high, addr 0x40 -> mem_write = 1, mem_read = 0, mem_wdata = dem_wdata; single dem_resp.
